hazard_ctrl: RTL

Pipeline hazard and flow controller for the 5-stage RV32 core. It sits beside the ID stage and watches the instruction in ID, the destination and control bits of the instructions in EX and MEM, and the ID-stage jump decision. From these it drives the PC, IF/ID and ID/EX enables: load-use and compare-in-ID stalls, bubble insertion, and one-cycle IF/ID flush on taken jumps. A registered FSM with a stall down-counter keeps multi-cycle stalls correct while the pipeline is frozen.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_src_use_dec.sv | 51 +++++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the hazard/flow controller.
//   - RV32 major opcodes seen by the ID-stage source decoder
//   - bit positions of the EX-stage control word
//   - hazard FSM state encoding
package hazard_ctrl_pkg;

  localparam logic [6:0] R_TYPE_OP  = 7'b0110011;
  localparam logic [6:0] ADDI_OP    = 7'b0010011;
  localparam logic [6:0] LD_OP      = 7'b0000011;
  localparam logic [6:0] JALR_OP    = 7'b1100111;
  localparam logic [6:0] S_TYPE_OP  = 7'b0100011;
  localparam logic [6:0] SB_TYPE_OP = 7'b1100011;
  localparam logic [6:0] UJ_TYPE_OP = 7'b1101111;

  // ctrl_ex bit indices
  localparam int REG_WRITE = 6;
  localparam int MEM_READ  = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_ctrl_src_use_dec.sv
// src_use_dec: combinational decode of which source registers the ID
// instruction actually reads, and whether it resolves in ID (branch/JALR).
//   id_inst           in   instruction in ID
//   uses_rs1/uses_rs2 out  source field is a real operand
//   is_branch_or_jalr out  consumer compares/adds operands in ID
//   rs1/rs2           out  source register fields
module src_use_dec
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] id_inst,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            is_branch_or_jalr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2
);

  logic [6:0] opc;
  logic       unused_bits;

  assign opc         = id_inst[6:0];
  assign rs1         = id_inst[19:15];
  assign rs2         = id_inst[24:20];
  assign unused_bits = ^{id_inst[XLEN-1:25], id_inst[14:7]};

  always_comb begin
    uses_rs1          = 1'b0;
    uses_rs2          = 1'b0;
    is_branch_or_jalr = 1'b0;
    case (opc)
      R_TYPE_OP, S_TYPE_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      SB_TYPE_OP: begin
        uses_rs1          = 1'b1;
        uses_rs2          = 1'b1;
        is_branch_or_jalr = 1'b1;
      end
      ADDI_OP, LD_OP: uses_rs1 = 1'b1;
      JALR_OP: begin
        uses_rs1          = 1'b1;
        is_branch_or_jalr = 1'b1;
      end
      default: ; // JAL (UJ_TYPE_OP) and unknown opcodes read nothing
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / compare-in-ID stall and jump flush controller.
//   clk, reset_n                    clock, async active-low reset
//   id_inst                         instruction in ID
//   ex_rd/ex_reg_write/ex_mem_read  EX destination and control bits
//   mem_rd/mem_mem_read             MEM destination and load flag
//   control_j                       ID-stage taken jump/branch
//   pc_write/ifid_write             pipeline front-end enables
//   ifid_flush/idex_bubble          squash IF/ID, zero ID/EX control
//   stall_cnt                       cumulative frozen cycles
//   state                           FSM state (debug)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] id_inst,
  input  logic [XLEN-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [XLEN-1:0] mem_rd,
  input  logic            mem_mem_read,
  input  logic            control_j,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [XLEN-1:0] stall_cnt,
  output logic [1:0]      state
);

  logic             uses_rs1, uses_rs2, is_bj;
  logic [4:0]       rs1, rs2;
  logic             ex_match, mem_match;
  logic [CNT_W-1:0] n_stall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_rd;

  assign unused_rd = ^{ex_rd[XLEN-1:5], mem_rd[XLEN-1:5]};

  src_use_dec #(.XLEN(XLEN)) u_dec (
    .id_inst          (id_inst),
    .uses_rs1         (uses_rs1),
    .uses_rs2         (uses_rs2),
    .is_branch_or_jalr(is_bj),
    .rs1              (rs1),
    .rs2              (rs2)
  );

  // x0 never carries a dependency
  assign ex_match  = (ex_rd[4:0] != 5'd0) &&
                     ((uses_rs1 && rs1 == ex_rd[4:0]) || (uses_rs2 && rs2 == ex_rd[4:0]));
  assign mem_match = (mem_rd[4:0] != 5'd0) &&
                     ((uses_rs1 && rs1 == mem_rd[4:0]) || (uses_rs2 && rs2 == mem_rd[4:0]));

  // Stall depth is the max over the rules, so overlapping EX/MEM loads
  // give 2, never a sum.
  always_comb begin
    n_stall = '0;
    if (is_bj && ex_mem_read && ex_match)
      n_stall = CNT_W'(2);
    else if ((ex_mem_read && ex_match) ||
             (is_bj && ex_reg_write && !ex_mem_read && ex_match) ||
             (is_bj && mem_mem_read && mem_match))
      n_stall = CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (n_stall != '0) begin
            // hazard beats a simultaneous jump; jump is re-decided later
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (n_stall > CNT_W'(1)) begin
              state_d = STALL;
              cnt_d   = n_stall - CNT_W'(1);
            end
          end else if (control_j) begin
            ifid_flush = 1'b1;
            state_d    = FLUSH;
          end
        end
        STALL: begin
          // frozen: control_j is stale and hazards are not re-evaluated
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        FLUSH: begin
          idex_bubble = 1'b1;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write) stall_cnt <= stall_cnt + XLEN'(1);
    end
  end

  assign state = state_q;

endmodule
